// File: rtl/cis_line_sequencer_if.sv
// Signal bundle between the CIS line sequencer and its controller / scan datapath.
// The sequencer takes the slave view; the controller side takes the master view.
interface cis_line_sequencer_if #(
  parameter int PIX_W = 14
);
  logic             enable;
  logic             dpi_mode;
  logic [PIX_W-1:0] line_pixels;

  logic             CISCLK;
  logic             CISSI;
  logic             dpi_mode_lat;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_idx;
  logic             line_start;
  logic             line_done;
  logic [15:0]      line_cnt;
  logic             busy;

  modport master (
    output enable, dpi_mode, line_pixels,
    input  CISCLK, CISSI, dpi_mode_lat, pix_valid, pix_idx,
           line_start, line_done, line_cnt, busy
  );

  modport slave (
    input  enable, dpi_mode, line_pixels,
    output CISCLK, CISSI, dpi_mode_lat, pix_valid, pix_idx,
           line_start, line_done, line_cnt, busy
  );
endinterface

// File: rtl/cis_line_sequencer.sv
// CIS timing generator: divides clk into CISCLK, frames each line with CISSI,
// and emits per-pixel strobes plus line bookkeeping to the scan datapath.
module cis_line_sequencer #(
  parameter int CLK_DIV  = 4,
  parameter int PIX_W    = 14,
  parameter int SI_WIDTH = 1,
  parameter int GAP_CLKS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cis_line_sequencer_if.slave   bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int SI_W  = $clog2(SI_WIDTH + 1);
  localparam int GAP_W = $clog2(GAP_CLKS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [SI_W-1:0]  SI_LAST  = SI_W'(SI_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SI,
    ST_READOUT,
    ST_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [SI_W-1:0]  si_q, si_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [PIX_W-1:0] npix_q, npix_d;
  logic             dpi_q, dpi_d;
  logic             cisclk_q, cisclk_d;
  logic             cissi_q, cissi_d;
  logic             pv_q, pv_d;
  logic [PIX_W-1:0] idx_q, idx_d;
  logic             ls_q, ls_d;
  logic             ld_q, ld_d;
  logic [15:0]      line_cnt_q, line_cnt_d;

  logic run;
  logic fall_ev;
  logic start;

  // Divider free-runs while a line is in flight or scanning is requested.
  always_comb begin
    run      = (state_q != ST_IDLE) || bus.enable;
    fall_ev  = run && (div_q == DIV_HALF);
    div_d    = '0;
    if (run) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
    cisclk_d = run && (div_d < DIV_HALF);
  end

  // NOTE: every signal gets its hold/idle value before the case so no path
  // through this block leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    si_d       = si_q;
    gap_d      = gap_q;
    pix_d      = pix_q;
    npix_d     = npix_q;
    dpi_d      = dpi_q;
    cissi_d    = cissi_q;
    pv_d       = 1'b0;
    idx_d      = idx_q;
    ls_d       = 1'b0;
    ld_d       = 1'b0;
    line_cnt_d = line_cnt_q;
    start      = 1'b0;

    if (fall_ev) begin
      unique case (state_q)
        ST_IDLE: begin
          start = bus.enable;
        end

        ST_SI: begin
          if (si_q == SI_LAST) begin
            cissi_d = 1'b0;
            if (npix_q == '0) begin
              state_d    = ST_GAP;
              gap_d      = '0;
              ld_d       = 1'b1;
              line_cnt_d = line_cnt_q + 16'd1;
            end else begin
              state_d = ST_READOUT;
              pix_d   = '0;
            end
          end else begin
            si_d = si_q + 1'b1;
          end
        end

        ST_READOUT: begin
          pv_d  = 1'b1;
          idx_d = pix_q;
          if (pix_q == npix_q - PIX_W'(1)) begin
            state_d    = ST_GAP;
            gap_d      = '0;
            ld_d       = 1'b1;
            line_cnt_d = line_cnt_q + 16'd1;
          end else begin
            pix_d = pix_q + PIX_W'(1);
          end
        end

        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            if (bus.enable) begin
              start = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end

        default: state_d = ST_IDLE;
      endcase

      // Line inputs are captured only here, so mid-line changes wait a line.
      if (start) begin
        state_d = ST_SI;
        si_d    = '0;
        npix_d  = bus.line_pixels;
        dpi_d   = bus.dpi_mode;
        cissi_d = 1'b1;
        ls_d    = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      si_q       <= '0;
      gap_q      <= '0;
      pix_q      <= '0;
      npix_q     <= '0;
      dpi_q      <= 1'b0;
      cisclk_q   <= 1'b0;
      cissi_q    <= 1'b0;
      pv_q       <= 1'b0;
      idx_q      <= '0;
      ls_q       <= 1'b0;
      ld_q       <= 1'b0;
      line_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      si_q       <= si_d;
      gap_q      <= gap_d;
      pix_q      <= pix_d;
      npix_q     <= npix_d;
      dpi_q      <= dpi_d;
      cisclk_q   <= cisclk_d;
      cissi_q    <= cissi_d;
      pv_q       <= pv_d;
      idx_q      <= idx_d;
      ls_q       <= ls_d;
      ld_q       <= ld_d;
      line_cnt_q <= line_cnt_d;
    end
  end

  assign bus.CISCLK       = cisclk_q;
  assign bus.CISSI        = cissi_q;
  assign bus.dpi_mode_lat = dpi_q;
  assign bus.pix_valid    = pv_q;
  assign bus.pix_idx      = idx_q;
  assign bus.line_start   = ls_q;
  assign bus.line_done    = ld_q;
  assign bus.line_cnt     = line_cnt_q;
  assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cis_line_sequencer.sv
// Self-checking bench for cis_line_sequencer: a line-schedule model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_cis_line_sequencer;

  localparam int CLK_DIV  = 4;
  localparam int PIX_W    = 14;
  localparam int SI_WIDTH = 1;
  localparam int GAP_CLKS = 2;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  cis_line_sequencer_if #(.PIX_W(PIX_W)) bus ();

  cis_line_sequencer #(
    .CLK_DIV (CLK_DIV),
    .PIX_W   (PIX_W),
    .SI_WIDTH(SI_WIDTH),
    .GAP_CLKS(GAP_CLKS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each line is a schedule of fall events relative to its start.
  // rel 0: line_start, CISSI high; rel SI_WIDTH+1..SI_WIDTH+npix: pixels;
  // rel SI_WIDTH+npix: line_done; rel SI_WIDTH+npix+GAP_CLKS: next line or idle.
  int   m_since, m_rel, m_npix;
  bit   m_in_line, m_dpi, m_run, m_fall, m_start, preload;
  logic [15:0] m_cnt;
  bit   e_clk, e_cissi, e_ls, e_pv, e_done;
  int   e_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_since = 0; m_rel = 0; m_npix = 0; m_in_line = 0; m_dpi = 0; m_cnt = '0;
      e_clk = 0; e_cissi = 0; e_ls = 0; e_pv = 0; e_done = 0; e_idx = 0;
    end else begin
      m_run   = m_in_line || bus.enable;
      m_fall  = m_run && ((m_since % CLK_DIV) == CLK_DIV / 2);
      m_since = m_run ? m_since + 1 : 0;
      e_ls = 0; e_pv = 0; e_done = 0;
      if (preload) m_cnt = 16'hFFFE;
      if (m_fall) begin
        m_start = 0;
        if (!m_in_line) begin
          m_start = bus.enable;
        end else begin
          m_rel++;
          if (m_rel == SI_WIDTH + m_npix + GAP_CLKS) begin
            if (bus.enable) m_start = 1;
            else m_in_line = 0;
          end
        end
        if (m_start) begin
          m_in_line = 1; m_rel = 0;
          m_npix = int'(bus.line_pixels); m_dpi = bus.dpi_mode; e_ls = 1;
        end
        if (m_in_line && m_rel >= SI_WIDTH + 1 && m_rel <= SI_WIDTH + m_npix) begin
          e_pv = 1; e_idx = m_rel - SI_WIDTH - 1;
        end
        if (m_in_line && m_rel == SI_WIDTH + m_npix) begin
          e_done = 1; m_cnt = m_cnt + 16'd1;
        end
      end
      e_cissi = m_in_line && (m_rel < SI_WIDTH);
      e_clk   = m_run && ((m_since % CLK_DIV) < CLK_DIV / 2);
    end
  end

  // Per-cycle comparison against the model, plus event recording.
  int ls_cyc[$];
  int pix_q[$];
  int done_cnt;

  always @(negedge clk) begin
    if (cyc >= 2) begin
      check("cisclk",       bus.CISCLK,       e_clk);
      check("cissi",        bus.CISSI,        e_cissi);
      check("line_start",   bus.line_start,   e_ls);
      check("pix_valid",    bus.pix_valid,    e_pv);
      if (e_pv) check("pix_idx", bus.pix_idx, e_idx);
      check("line_done",    bus.line_done,    e_done);
      check("line_cnt",     bus.line_cnt,     m_cnt);
      check("busy",         bus.busy,         m_in_line);
      check("dpi_mode_lat", bus.dpi_mode_lat, m_dpi);
    end
    if (bus.line_start) ls_cyc.push_back(cyc);
    if (bus.pix_valid)  pix_q.push_back(int'(bus.pix_idx));
    if (bus.line_done)  done_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ls(input int budget);
    int n = ls_cyc.size();
    int k = 0;
    while (ls_cyc.size() == n && k < budget) begin step(); k++; end
    check("wait_line_start", ls_cyc.size() != n, 1);
  endtask

  task automatic wait_done(input int budget);
    int n = done_cnt;
    int k = 0;
    while (done_cnt == n && k < budget) begin step(); k++; end
    check("wait_line_done", done_cnt != n, 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (bus.busy && k < budget) begin step(); k++; end
    check("wait_idle", bus.busy, 0);
  endtask

  initial begin
    int highs, rises, n, rel;
    bit prev;
    checks = 0; errors = 0; done_cnt = 0; preload = 0;
    rst_n = 1'b0;
    bus.enable = 1'b0; bus.dpi_mode = 1'b0; bus.line_pixels = PIX_W'(5);
    repeat (3) step();
    check("rst_cisclk", bus.CISCLK, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_line_cnt", bus.line_cnt, 0);
    check("rst_cissi", bus.CISSI, 0);
    rst_n = 1'b1;
    repeat (3) step();
    check("idle_cisclk", bus.CISCLK, 0);

    // T1: continuous 5-pixel lines
    pix_q.delete();
    bus.enable = 1'b1;
    wait_ls(100);
    wait_ls(100);
    check("t1_period_a", ls_cyc[1] - ls_cyc[0], 32);
    check("t1_pix_count", pix_q.size(), 5);
    for (int i = 0; i < 5; i++) check("t1_pix_order", pix_q[i], i);
    wait_ls(100);
    check("t1_period_b", ls_cyc[2] - ls_cyc[1], 32);
    highs = 0; rises = 0; prev = bus.CISCLK;
    for (int i = 0; i < 16; i++) begin
      step();
      if (bus.CISCLK) highs++;
      if (bus.CISCLK && !prev) rises++;
      prev = bus.CISCLK;
    end
    check("t1_cisclk_high", highs, 8);
    check("t1_cisclk_rises", rises, 4);

    // T2: drop enable at pixel 2
    n = 0;
    while (!(bus.pix_valid && bus.pix_idx == PIX_W'(2)) && n < 100) begin step(); n++; end
    check("t2_found_pix2", bus.pix_valid, 1);
    pix_q.delete(); done_cnt = 0; n = ls_cyc.size();
    bus.enable = 1'b0;
    wait_idle(200);
    check("t2_pix_count", pix_q.size(), 2);
    if (pix_q.size() == 2) begin
      check("t2_pix3", pix_q[0], 3);
      check("t2_pix4", pix_q[1], 4);
    end
    check("t2_done", done_cnt, 1);
    repeat (10) step();
    check("t2_cisclk_low", bus.CISCLK, 0);
    check("t2_no_line_start", ls_cyc.size(), n);

    // T3: mid-line input change takes effect on the next line
    bus.enable = 1'b1;
    wait_ls(100);
    check("t3_dpi_first", bus.dpi_mode_lat, 0);
    bus.dpi_mode = 1'b1; bus.line_pixels = PIX_W'(3);
    pix_q.delete();
    wait_ls(100);
    check("t3_first_pix", pix_q.size(), 5);
    check("t3_dpi_second", bus.dpi_mode_lat, 1);
    pix_q.delete();
    wait_ls(100);
    check("t3_second_pix", pix_q.size(), 3);
    check("t3_period", ls_cyc[$] - ls_cyc[$-1], 24);

    // T4: zero-pixel lines
    bus.line_pixels = '0;
    wait_ls(100);
    pix_q.delete(); done_cnt = 0;
    wait_ls(100);
    check("t4_no_pix", pix_q.size(), 0);
    check("t4_done", done_cnt, 1);
    check("t4_period", ls_cyc[$] - ls_cyc[$-1], 12);

    // T5: line_cnt wrap
    bus.enable = 1'b0;
    wait_idle(100);
    step();
    force dut.line_cnt_q = 16'hFFFE;
    preload = 1;
    step();
    preload = 0;
    release dut.line_cnt_q;
    step();
    check("t5_preload", bus.line_cnt, 16'hFFFE);
    bus.enable = 1'b1;
    wait_done(100);
    check("t5_ffff", bus.line_cnt, 16'hFFFF);
    wait_done(100);
    check("t5_wrap_done", bus.line_done, 1);
    check("t5_wrap_cnt", bus.line_cnt, 0);

    // T6: reset while CISSI is high
    n = 0;
    while (!bus.CISSI && n < 50) begin step(); n++; end
    check("t6_found_si", bus.CISSI, 1);
    rst_n = 1'b0;
    #1;
    check("t6_cissi", bus.CISSI, 0);
    check("t6_cisclk", bus.CISCLK, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_line_cnt", bus.line_cnt, 0);
    check("t6_line_start", bus.line_start, 0);
    check("t6_pix_valid", bus.pix_valid, 0);
    check("t6_dpi_lat", bus.dpi_mode_lat, 0);
    repeat (2) step();
    rst_n = 1'b1;
    rel = cyc;
    wait_ls(20);
    check("t6_first_ls", ls_cyc[$] - rel, 3);
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
